// File: rtl/etile_tx_pkt_arbiter.sv
// Packet-level round-robin arbiter feeding one E-Tile EHIP TX AVST port.
// A granted source owns the port from SOP to EOP; every TX beat is registered.
module etile_tx_pkt_arbiter #(
    parameter int CHANNELS    = 4,
    parameter int DATA_WIDTH  = 512,
    parameter int EMPTY_WIDTH = 6,
    parameter int ERROR_WIDTH = 1
) (
    input  logic                            CLK,
    input  logic                            RESET_N,
    input  logic [CHANNELS*DATA_WIDTH-1:0]  RX_DATA,
    input  logic [CHANNELS*EMPTY_WIDTH-1:0] RX_EMPTY,
    input  logic [CHANNELS*ERROR_WIDTH-1:0] RX_ERROR,
    input  logic [CHANNELS-1:0]             RX_SOP,
    input  logic [CHANNELS-1:0]             RX_EOP,
    input  logic [CHANNELS-1:0]             RX_VALID,
    output logic [CHANNELS-1:0]             RX_READY,
    output logic [DATA_WIDTH-1:0]           TX_DATA,
    output logic [EMPTY_WIDTH-1:0]          TX_EMPTY,
    output logic [ERROR_WIDTH-1:0]          TX_ERROR,
    output logic                            TX_SOP,
    output logic                            TX_EOP,
    output logic                            TX_VALID,
    input  logic                            TX_READY,
    output logic [$clog2(CHANNELS)-1:0]     TX_CHAN,
    output logic                            PROTO_ERR
);

    localparam int CW = $clog2(CHANNELS);

    typedef enum logic {IDLE, PKT} state_t;

    state_t                  state_reg, state_next;
    logic [CW-1:0]           gnt_reg, gnt_next;
    logic [CW-1:0]           ptr_reg, ptr_next;

    logic                    tx_valid_reg;
    logic [DATA_WIDTH-1:0]   tx_data_reg;
    logic [EMPTY_WIDTH-1:0]  tx_empty_reg;
    logic [ERROR_WIDTH-1:0]  tx_error_reg;
    logic                    tx_sop_reg;
    logic                    tx_eop_reg;
    logic [CW-1:0]           tx_chan_reg;
    logic                    proto_err_reg;

    logic [DATA_WIDTH-1:0]   ch_data  [CHANNELS];
    logic [EMPTY_WIDTH-1:0]  ch_empty [CHANNELS];
    logic [ERROR_WIDTH-1:0]  ch_error [CHANNELS];

    logic                    can_load;
    logic                    load;
    logic [CW-1:0]           load_chan;
    logic                    sel_found;
    logic [CW-1:0]           sel_idx;
    logic [CHANNELS-1:0]     eligible;
    logic [CHANNELS-1:0]     held;
    logic [CHANNELS-1:0]     proto_hit;
    logic [CHANNELS-1:0]     rx_ready_c;

    generate
        for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_slice
            assign ch_data[gi]  = RX_DATA[gi*DATA_WIDTH +: DATA_WIDTH];
            assign ch_empty[gi] = RX_EMPTY[gi*EMPTY_WIDTH +: EMPTY_WIDTH];
            assign ch_error[gi] = RX_ERROR[gi*ERROR_WIDTH +: ERROR_WIDTH];
        end
    endgenerate

    // The output register takes a beat when empty or draining this cycle.
    assign can_load = !tx_valid_reg || TX_READY;
    assign eligible = RX_VALID & RX_SOP;

    // First SOP requester at or after PTR, wrapping around.
    always_comb begin
        int idx;
        idx       = 0;
        sel_found = 1'b0;
        sel_idx   = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            idx = int'(ptr_reg) + k;
            if (idx >= CHANNELS) idx = idx - CHANNELS;
            if (!sel_found && eligible[idx]) begin
                sel_found = 1'b1;
                sel_idx   = CW'(idx);
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        gnt_next   = gnt_reg;
        ptr_next   = ptr_reg;
        rx_ready_c = '0;
        load       = 1'b0;
        load_chan  = gnt_reg;
        case (state_reg)
            IDLE: begin
                if (sel_found && can_load) begin
                    rx_ready_c[sel_idx] = 1'b1;
                    load                = 1'b1;
                    load_chan           = sel_idx;
                    gnt_next            = sel_idx;
                    ptr_next            = (int'(sel_idx) == CHANNELS - 1) ? '0 : sel_idx + 1'b1;
                    if (!RX_EOP[sel_idx]) state_next = PKT;
                end
            end
            PKT: begin
                rx_ready_c[gnt_reg] = can_load;
                if (RX_VALID[gnt_reg] && can_load) begin
                    load = 1'b1;
                    if (RX_EOP[gnt_reg]) state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Mid-packet beats are legal only from the channel that owns the port.
    always_comb begin
        held = '0;
        if (state_reg == PKT) held[gnt_reg] = 1'b1;
        proto_hit = RX_VALID & ~RX_SOP & ~held;
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_reg     <= IDLE;
            gnt_reg       <= '0;
            ptr_reg       <= '0;
            tx_valid_reg  <= 1'b0;
            tx_data_reg   <= '0;
            tx_empty_reg  <= '0;
            tx_error_reg  <= '0;
            tx_sop_reg    <= 1'b0;
            tx_eop_reg    <= 1'b0;
            tx_chan_reg   <= '0;
            proto_err_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            gnt_reg   <= gnt_next;
            ptr_reg   <= ptr_next;
            if (load) begin
                tx_valid_reg <= 1'b1;
                tx_data_reg  <= ch_data[load_chan];
                tx_empty_reg <= ch_empty[load_chan];
                tx_error_reg <= ch_error[load_chan];
                tx_sop_reg   <= RX_SOP[load_chan];
                tx_eop_reg   <= RX_EOP[load_chan];
                tx_chan_reg  <= load_chan;
            end else if (TX_READY) begin
                tx_valid_reg <= 1'b0;
            end
            if (|proto_hit) proto_err_reg <= 1'b1;
        end
    end

    assign RX_READY  = rx_ready_c;
    assign TX_VALID  = tx_valid_reg;
    assign TX_DATA   = tx_data_reg;
    assign TX_EMPTY  = tx_empty_reg;
    assign TX_ERROR  = tx_error_reg;
    assign TX_SOP    = tx_sop_reg;
    assign TX_EOP    = tx_eop_reg;
    assign TX_CHAN   = tx_chan_reg;
    assign PROTO_ERR = proto_err_reg;

endmodule

// File: tb/tb_etile_tx_pkt_arbiter.sv
// Self-checking bench for etile_tx_pkt_arbiter: directed scenarios plus a
// randomized run scored against per-channel queues and a round-robin model.
module tb_etile_tx_pkt_arbiter;

    localparam int CH = 4;
    localparam int DW = 32;
    localparam int EW = 6;
    localparam int RW = 1;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [EW-1:0] empty;
        logic          err;
        logic          sop;
        logic          eop;
    } beat_t;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [CH*DW-1:0] rx_data;
    logic [CH*EW-1:0] rx_empty;
    logic [CH*RW-1:0] rx_error;
    logic [CH-1:0]    rx_sop, rx_eop, rx_valid, rx_ready;
    logic [DW-1:0]    tx_data;
    logic [EW-1:0]    tx_empty;
    logic [RW-1:0]    tx_error;
    logic             tx_sop, tx_eop, tx_valid, tx_ready;
    logic [1:0]       tx_chan;
    logic             proto_err;

    beat_t src_q [CH][$];
    beat_t exp_q [CH][$];
    logic [CH-1:0] acc_v;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    etile_tx_pkt_arbiter #(
        .CHANNELS(CH), .DATA_WIDTH(DW), .EMPTY_WIDTH(EW), .ERROR_WIDTH(RW)
    ) dut (
        .CLK(clk), .RESET_N(rst_n),
        .RX_DATA(rx_data), .RX_EMPTY(rx_empty), .RX_ERROR(rx_error),
        .RX_SOP(rx_sop), .RX_EOP(rx_eop), .RX_VALID(rx_valid), .RX_READY(rx_ready),
        .TX_DATA(tx_data), .TX_EMPTY(tx_empty), .TX_ERROR(tx_error),
        .TX_SOP(tx_sop), .TX_EOP(tx_eop), .TX_VALID(tx_valid), .TX_READY(tx_ready),
        .TX_CHAN(tx_chan), .PROTO_ERR(proto_err)
    );

    // Each source presents its queue head continuously while it has data.
    task automatic drive();
        beat_t b;
        for (int c = 0; c < CH; c++) begin
            b = '0;
            if (src_q[c].size() > 0) b = src_q[c][0];
            rx_valid[c]          = (src_q[c].size() > 0);
            rx_data[c*DW +: DW]  = b.data;
            rx_empty[c*EW +: EW] = b.empty;
            rx_error[c]          = b.err;
            rx_sop[c]            = b.sop;
            rx_eop[c]            = b.eop;
        end
    endtask

    task automatic clear_queues();
        for (int c = 0; c < CH; c++) begin
            src_q[c].delete();
            exp_q[c].delete();
        end
    endtask

    task automatic add_pkt(input int c, input int len, input logic [EW-1:0] last_empty);
        beat_t b;
        for (int i = 0; i < len; i++) begin
            b.data  = $urandom;
            b.empty = (i == len - 1) ? last_empty : EW'($urandom_range(0, 63));
            b.err   = 1'($urandom_range(0, 1));
            b.sop   = (i == 0);
            b.eop   = (i == len - 1);
            src_q[c].push_back(b);
            exp_q[c].push_back(b);
        end
    endtask

    function automatic beat_t current_tx();
        beat_t b;
        b.data  = tx_data;
        b.empty = tx_empty;
        b.err   = tx_error[0];
        b.sop   = tx_sop;
        b.eop   = tx_eop;
        return b;
    endfunction

    // Called at a negedge; returns at the next negedge with sources updated.
    task automatic advance();
        #1;
        acc_v = rx_valid & rx_ready;
        @(posedge clk);
        #1;
        for (int c = 0; c < CH; c++)
            if (acc_v[c]) void'(src_q[c].pop_front());
        drive();
        @(negedge clk);
    endtask

    task automatic apply_reset();
        rst_n    = 1'b0;
        tx_ready = 1'b1;
        clear_queues();
        drive();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL reset_tx_valid got=%b exp=0", tx_valid); end
        checks++; if (tx_sop !== 1'b0) begin errors++; $display("FAIL reset_tx_sop got=%b exp=0", tx_sop); end
        checks++; if (tx_eop !== 1'b0) begin errors++; $display("FAIL reset_tx_eop got=%b exp=0", tx_eop); end
        checks++; if (tx_data !== '0) begin errors++; $display("FAIL reset_tx_data got=%h exp=0", tx_data); end
        checks++; if (tx_empty !== '0) begin errors++; $display("FAIL reset_tx_empty got=%0d exp=0", tx_empty); end
        checks++; if (tx_error !== '0) begin errors++; $display("FAIL reset_tx_error got=%b exp=0", tx_error); end
        checks++; if (tx_chan !== 2'd0) begin errors++; $display("FAIL reset_tx_chan got=%0d exp=0", tx_chan); end
        checks++; if (proto_err !== 1'b0) begin errors++; $display("FAIL reset_proto_err got=%b exp=0", proto_err); end
        checks++; if (rx_ready !== 4'b0000) begin errors++; $display("FAIL reset_rx_ready got=%b exp=0000", rx_ready); end
        rst_n = 1'b1;
        $display("reset: done");
    endtask

    task automatic test_single();
        beat_t b;
        apply_reset();
        add_pkt(1, 3, 6'd13);
        drive();
        #1;
        checks++; if (rx_ready !== 4'b0010) begin errors++; $display("FAIL single_ready got=%b exp=0010", rx_ready); end
        checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL single_pre_valid got=%b exp=0", tx_valid); end
        for (int k = 0; k < 3; k++) begin
            advance();
            b = exp_q[1].pop_front();
            checks++;
            if (tx_valid !== 1'b1 || tx_chan !== 2'd1 || current_tx() !== b || tx_sop !== (k == 0) || tx_eop !== (k == 2)) begin
                errors++;
                $display("FAIL single_beat%0d got v=%b ch=%0d d=%h sop=%b eop=%b e=%0d exp v=1 ch=1 d=%h sop=%b eop=%b e=%0d",
                         k, tx_valid, tx_chan, tx_data, tx_sop, tx_eop, tx_empty, b.data, b.sop, b.eop, b.empty);
            end
            $display("single: beat %0d ch=%0d data=%h", k, tx_chan, tx_data);
        end
        checks++; if (tx_empty !== 6'd13) begin errors++; $display("FAIL single_eop_empty got=%0d exp=13", tx_empty); end
        advance();
        checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL single_post_valid got=%b exp=0", tx_valid); end
    endtask

    task automatic test_round_robin();
        beat_t b;
        int expc;
        apply_reset();
        for (int c = 0; c < CH; c++)
            for (int p = 0; p < 3; p++) add_pkt(c, 2, EW'($urandom_range(0, 63)));
        drive();
        #1;
        for (int j = 0; j <= 10; j++) begin
            if (j < 10) begin
                checks++;
                if (rx_ready !== 4'(1 << ((j / 2) % CH))) begin
                    errors++; $display("FAIL rr_ready%0d got=%b exp=%b", j, rx_ready, 4'(1 << ((j / 2) % CH)));
                end
            end
            if (j > 0) begin
                expc = ((j - 1) / 2) % CH;
                b = exp_q[expc].pop_front();
                checks++;
                if (tx_valid !== 1'b1 || tx_chan !== 2'(expc) || tx_data !== b.data || tx_sop !== ((j - 1) % 2 == 0)) begin
                    errors++;
                    $display("FAIL rr_beat%0d got v=%b ch=%0d d=%h sop=%b exp v=1 ch=%0d d=%h sop=%b",
                             j - 1, tx_valid, tx_chan, tx_data, tx_sop, expc, b.data, b.sop);
                end
                $display("rr: beat %0d ch=%0d", j - 1, tx_chan);
            end
            if (j < 10) advance();
        end
    endtask

    task automatic test_mid_packet();
        apply_reset();
        add_pkt(2, 4, 6'd0);
        drive();
        advance();
        add_pkt(0, 2, 6'd0);
        drive();
        #1;
        for (int n = 1; n <= 5; n++) begin
            if (n <= 4) begin
                checks++;
                if (rx_ready !== ((n < 4) ? 4'b0100 : 4'b0001)) begin
                    errors++; $display("FAIL mid_ready%0d got=%b exp=%b", n, rx_ready, (n < 4) ? 4'b0100 : 4'b0001);
                end
            end
            checks++;
            if (tx_valid !== 1'b1 || tx_chan !== ((n < 5) ? 2'd2 : 2'd0) || tx_sop !== (n == 1 || n == 5) || tx_eop !== (n == 4)) begin
                errors++;
                $display("FAIL mid_tx%0d got v=%b ch=%0d sop=%b eop=%b exp v=1 ch=%0d sop=%b eop=%b",
                         n, tx_valid, tx_chan, tx_sop, tx_eop, (n < 5) ? 2 : 0, (n == 1 || n == 5), (n == 4));
            end
            $display("mid: cycle %0d tx ch=%0d sop=%b eop=%b", n, tx_chan, tx_sop, tx_eop);
            if (n < 5) advance();
        end
    endtask

    task automatic test_backpressure();
        beat_t got[$];
        beat_t held, b;
        int n;
        apply_reset();
        add_pkt(1, 6, 6'd9);
        drive();
        n = 0;
        held = '0;
        while (got.size() < 6 && n < 40) begin
            tx_ready = !(n >= 2 && n < 7);
            #1;
            if (n == 2) held = current_tx();
            if (n >= 2 && n < 7) begin
                checks++;
                if (tx_valid !== 1'b1 || current_tx() !== held) begin
                    errors++; $display("FAIL bp_hold%0d got v=%b d=%h exp v=1 d=%h", n, tx_valid, tx_data, held.data);
                end
                checks++;
                if (rx_ready !== 4'b0000) begin
                    errors++; $display("FAIL bp_ready%0d got=%b exp=0000", n, rx_ready);
                end
            end
            if (tx_valid && tx_ready) begin
                got.push_back(current_tx());
                $display("bp: beat %0d data=%h", got.size() - 1, tx_data);
            end
            advance();
            n++;
        end
        tx_ready = 1'b1;
        checks++;
        if (got.size() != 6) begin errors++; $display("FAIL bp_count got=%0d exp=6", got.size()); end
        for (int i = 0; i < got.size() && exp_q[1].size() > 0; i++) begin
            b = exp_q[1].pop_front();
            checks++;
            if (got[i] !== b) begin errors++; $display("FAIL bp_beat%0d got=%h exp=%h", i, got[i].data, b.data); end
        end
    endtask

    task automatic test_proto_err();
        beat_t bad;
        apply_reset();
        bad = '{data: 32'hBAD0_0003, empty: '0, err: 1'b0, sop: 1'b0, eop: 1'b0};
        src_q[3].push_back(bad);
        add_pkt(1, 2, 6'd5);
        drive();
        #1;
        checks++; if (rx_ready !== 4'b0010) begin errors++; $display("FAIL proto_ready got=%b exp=0010", rx_ready); end
        checks++; if (proto_err !== 1'b0) begin errors++; $display("FAIL proto_early got=%b exp=0", proto_err); end
        advance();
        checks++; if (proto_err !== 1'b1) begin errors++; $display("FAIL proto_set got=%b exp=1", proto_err); end
        checks++;
        if (tx_valid !== 1'b1 || tx_chan !== 2'd1 || tx_sop !== 1'b1) begin
            errors++; $display("FAIL proto_serve got v=%b ch=%0d sop=%b exp v=1 ch=1 sop=1", tx_valid, tx_chan, tx_sop);
        end
        advance();
        checks++;
        if (tx_valid !== 1'b1 || tx_chan !== 2'd1 || tx_eop !== 1'b1) begin
            errors++; $display("FAIL proto_serve_eop got v=%b ch=%0d eop=%b exp v=1 ch=1 eop=1", tx_valid, tx_chan, tx_eop);
        end
        advance();
        advance();
        #1;
        checks++; if (proto_err !== 1'b1) begin errors++; $display("FAIL proto_sticky got=%b exp=1", proto_err); end
        checks++; if (rx_ready[3] !== 1'b0) begin errors++; $display("FAIL proto_stall got=%b exp=0", rx_ready[3]); end
        checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL proto_idle got=%b exp=0", tx_valid); end
        $display("proto: done");
    endtask

    task automatic test_reset_mid_packet();
        apply_reset();
        add_pkt(2, 4, 6'd0);
        drive();
        advance();
        advance();
        checks++;
        if (tx_valid !== 1'b1 || tx_chan !== 2'd2 || tx_sop !== 1'b0) begin
            errors++; $display("FAIL rstmid_pre got v=%b ch=%0d sop=%b exp v=1 ch=2 sop=0", tx_valid, tx_chan, tx_sop);
        end
        rst_n = 1'b0;
        #1;
        checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL rstmid_async got=%b exp=0", tx_valid); end
        clear_queues();
        drive();
        @(negedge clk);
        rst_n = 1'b1;
        add_pkt(3, 1, 6'd1);
        add_pkt(1, 1, 6'd2);
        drive();
        #1;
        checks++; if (rx_ready !== 4'b0010) begin errors++; $display("FAIL rstmid_ready got=%b exp=0010", rx_ready); end
        advance();
        checks++; if (tx_valid !== 1'b1 || tx_chan !== 2'd1) begin errors++; $display("FAIL rstmid_first got v=%b ch=%0d exp v=1 ch=1", tx_valid, tx_chan); end
        advance();
        checks++; if (tx_valid !== 1'b1 || tx_chan !== 2'd3) begin errors++; $display("FAIL rstmid_second got v=%b ch=%0d exp v=1 ch=3", tx_valid, tx_chan); end
    endtask

    task automatic test_random();
        int pend[CH];
        int mptr, total, seen, cyc, expc, c, idx;
        beat_t cur, prev, b;
        bit prev_stall;
        for (int round = 0; round < 3; round++) begin
            apply_reset();
            total = 0;
            for (int ch = 0; ch < CH; ch++) begin
                pend[ch] = $urandom_range(0, 4);
                for (int p = 0; p < pend[ch]; p++) add_pkt(ch, $urandom_range(1, 4), EW'($urandom_range(0, 63)));
                total += exp_q[ch].size();
            end
            drive();
            mptr = 0; seen = 0; cyc = 0; prev_stall = 1'b0; prev = '0;
            while (seen < total && cyc < 2000) begin
                tx_ready = ($urandom_range(0, 9) < 7);
                #1;
                cur = current_tx();
                if (prev_stall) begin
                    checks++;
                    if (tx_valid !== 1'b1 || cur !== prev) begin
                        errors++; $display("FAIL rand_stable got v=%b d=%h exp v=1 d=%h", tx_valid, cur.data, prev.data);
                    end
                end
                checks++;
                if ($countones(rx_ready) > 1) begin errors++; $display("FAIL rand_onehot got=%b exp=at most one", rx_ready); end
                if (tx_valid && tx_ready) begin
                    c = int'(tx_chan);
                    if (cur.sop) begin
                        expc = -1;
                        for (int k = 0; k < CH; k++) begin
                            idx = (mptr + k) % CH;
                            if (expc < 0 && pend[idx] > 0) expc = idx;
                        end
                        checks++;
                        if (c != expc) begin errors++; $display("FAIL rand_rr got ch=%0d exp ch=%0d", c, expc); end
                        if (expc >= 0) begin
                            pend[expc]--;
                            mptr = (expc + 1) % CH;
                        end
                    end
                    checks++;
                    if (exp_q[c].size() == 0) begin
                        errors++; $display("FAIL rand_extra got ch=%0d d=%h exp no beat", c, cur.data);
                    end else begin
                        b = exp_q[c].pop_front();
                        if (cur !== b) begin
                            errors++; $display("FAIL rand_beat got ch=%0d d=%h sop=%b eop=%b exp d=%h sop=%b eop=%b", c, cur.data, cur.sop, cur.eop, b.data, b.sop, b.eop);
                        end
                    end
                    seen++;
                    $display("rand: round %0d ch=%0d sop=%b eop=%b data=%h", round, c, cur.sop, cur.eop, cur.data);
                end
                prev_stall = tx_valid && !tx_ready;
                prev = cur;
                advance();
                cyc++;
            end
            tx_ready = 1'b1;
            checks++;
            if (seen != total) begin errors++; $display("FAIL rand_total round %0d got=%0d exp=%0d", round, seen, total); end
        end
    endtask

    initial begin
        rst_n    = 1'b0;
        tx_ready = 1'b1;
        acc_v    = '0;
        clear_queues();
        drive();
        test_reset();
        test_single();
        test_round_robin();
        test_mid_packet();
        test_backpressure();
        test_proto_err();
        test_reset_mid_packet();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/etile_tx_pkt_arbiter.md
# etile_tx_pkt_arbiter

Packet-level round-robin arbiter that lets several AVST packet sources share one E-Tile EHIP TX port (`tx_avst_*` of `network_mod_core`). A packet, once granted, owns the port from SOP to EOP. Every TX beat is registered, so the EHIP sees clean timing. The block sits in the CLK_ETH domain, directly in front of the E-Tile TX interface.

## Interface
Parameters:
- CHANNELS, 4, number of requesting AVST sources (≥2)
- DATA_WIDTH, 512, AVST data bits per beat
- EMPTY_WIDTH, 6, width of the EMPTY field (log2 of bytes per beat)
- ERROR_WIDTH, 1, width of the per-beat error field

Ports (clock and reset first):
- CLK  in  1  CLK_ETH of the port. This is the single clock of the block.
- RESET_N  in  1  Reset, asynchronous, active-low.
- RX_DATA  in  CHANNELS*DATA_WIDTH  Per-channel data. Channel i occupies slice i.
- RX_EMPTY  in  CHANNELS*EMPTY_WIDTH  Per-channel empty bytes. Meaningful on EOP only.
- RX_ERROR  in  CHANNELS*ERROR_WIDTH  Per-channel error field.
- RX_SOP / RX_EOP / RX_VALID  in  CHANNELS  Per-channel framing and valid.
- RX_READY  out  CHANNELS  Per-channel ready. Ready latency 0: a beat transfers on VALID&READY in the same cycle.
- TX_DATA  out  DATA_WIDTH  Output data. Drives tx_avst_data.
- TX_EMPTY  out  EMPTY_WIDTH  Output empty.
- TX_ERROR  out  ERROR_WIDTH  Output error.
- TX_SOP / TX_EOP / TX_VALID  out  1  Output framing and valid.
- TX_READY  in  1  tx_avst_ready[0] from EHIP. Ready latency 0.
- TX_CHAN  out  log2(CHANNELS)  Channel index of the beat currently on TX.
- PROTO_ERR  out  1  Sticky flag. Set when a channel presents VALID without SOP while it holds no grant.

## Operation
- FSM states are IDLE and PKT, with grant register GNT and round-robin pointer PTR. Reset values: IDLE, GNT=0, PTR=0.
- Output register OREG holds one beat plus TX_CHAN. The register can accept a new beat (`can_load`) when OREG is empty or TX_READY=1.
- IDLE:
  - Eligible channels have RX_VALID=1 and RX_SOP=1.
  - Selection is combinational, in the same cycle. The first eligible channel is searched from PTR, through CHANNELS-1, wrapping to 0 up to PTR-1.
  - If a channel c is selected and can_load=1: RX_READY[c]=1, the beat loads into OREG, GNT=c, and PTR=(c+1) mod CHANNELS.
  - If that beat has EOP, the FSM stays in IDLE; otherwise it goes to PKT.
- PKT: RX_READY[GNT]=can_load, and all other RX_READY bits are 0. Each beat of channel GNT loads when VALID&can_load. An accepted EOP returns the FSM to IDLE.
- PTR advances only on a grant, so a sole requester keeps winning. When every channel is backlogged, grants rotate in strict order.
- A non-granted channel with VALID=1 and SOP=0 is not eligible and stays stalled. Such a beat sets PROTO_ERR, which clears only on reset.
- OREG valid is cleared when TX_READY=1 and no new beat loads. TX_* hold stable while TX_VALID=1 and TX_READY=0, as the AVST rules require.
- SOP/EOP/EMPTY/ERROR pass through unmodified with the beat. The block does no length checking.

## Timing
- Reset values: TX_VALID=0, TX_SOP=0, TX_EOP=0, TX_DATA=0, TX_EMPTY=0, TX_ERROR=0, TX_CHAN=0, PROTO_ERR=0, RX_READY=0.
- Latency is exactly 1 cycle from an accepted RX beat to that beat on TX.
- Full throughput: one beat per cycle while TX_READY=1. There is no idle cycle between back-to-back packets, including when the channel switches at EOP→SOP.
- RX_READY is combinational from TX_READY, FSM state and RX_VALID/SOP. TX outputs come only from registers.
- TX_READY=0 with OREG full: can_load=0 and all RX_READY=0 in that cycle.
- Asserting RESET_N mid-packet aborts the packet immediately. TX_VALID drops asynchronously. After release, arbitration restarts in IDLE with PTR=0. Upstream sources must be reset together with the block.

## Test plan
- Single channel 1 sends a 3-beat packet with TX_READY=1 → TX_VALID on cycles t+1..t+3, SOP on the first beat, EOP on the last, TX_CHAN=1, data identical, EMPTY on EOP preserved (e.g. 13).
- All 4 channels continuously present 2-beat packets → TX_CHAN sequence 0,0,1,1,2,2,3,3,0,0 with no gap cycles. Each RX_READY is high only during its own packet.
- Channel 2 is mid-packet (SOP sent, 4-beat packet) while channel 0 raises SOP → channel 0 stays stalled until channel 2 EOP is accepted. Channel 0 SOP appears on TX in the cycle after channel 2 EOP.
- TX_READY is held low for 5 cycles mid-packet → TX beat stays stable with TX_VALID=1, all RX_READY=0, and nothing is lost or duplicated after release.
- Channel 3 presents VALID=1, SOP=0 in IDLE → RX_READY[3]=0, PROTO_ERR=1 from the next cycle and remains 1. Other channels are still served normally.
- RESET_N is pulsed low during beat 2 of a 4-beat packet → TX_VALID=0 immediately. After release, the first granted channel is the lowest eligible index, starting from PTR=0.
